// File: rtl/board_state.sv
// Registered tic-tac-toe board: validates and commits single-cell moves, then
// spends one CHECK cycle on win/draw evaluation of the committed board.
module board_state (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_new_game,
  input  logic        i_valid,
  input  logic [17:0] i_mask,
  input  logic        i_bad_move,
  input  logic        i_user,
  output logic        o_ready,
  output logic [17:0] o_board,
  output logic        o_turn,
  output logic        o_illegal,
  output logic [1:0]  o_result,
  output logic [3:0]  o_moves
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_e;

  localparam logic [17:0] LOW_BITS = 18'h15555;
  localparam logic [11:0] LINES [8] = '{12'h123, 12'h456, 12'h789, 12'h147,
                                        12'h258, 12'h369, 12'h159, 12'h357};

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic        illegal_q, illegal_d;
  logic [1:0]  result_q, result_d;
  logic [3:0]  moves_q, moves_d;

  logic        handshake;
  logic        reject;
  logic [1:0]  winner;
  logic [1:0]  ca, cb, cc;

  // Cell k (1..9) lives at bits [19-2k:18-2k].
  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] k);
    logic [17:0] s;
    s = b >> (5'd18 - {k, 1'b0});
    return s[1:0];
  endfunction

  always_comb begin : win_eval
    winner = 2'b00;
    ca     = 2'b00;
    cb     = 2'b00;
    cc     = 2'b00;
    // Reverse scan so the earliest line in the table takes priority.
    for (int i = 7; i >= 0; i--) begin
      ca = cell_of(board_q, LINES[i][11:8]);
      cb = cell_of(board_q, LINES[i][7:4]);
      cc = cell_of(board_q, LINES[i][3:0]);
      if (ca != 2'b00 && ca == cb && cb == cc) winner = ca;
    end
  end

  // Handshake: a move transfers on a rising edge where i_valid and o_ready are
  // both high; i_valid while o_ready is low is ignored and must be re-presented.
  assign handshake = i_valid && (state_q == PLAY);
  assign reject    = i_bad_move || (i_mask == 18'h0) || (i_user != turn_q) ||
                     (|((board_q | (board_q >> 1)) & i_mask & LOW_BITS));

  always_comb begin : next_state
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    illegal_d = 1'b0;
    result_d  = result_q;
    moves_d   = moves_q;
    if (i_new_game) begin
      state_d  = PLAY;
      board_d  = 18'h0;
      turn_d   = 1'b1;
      result_d = 2'b00;
      moves_d  = 4'd0;
    end else begin
      case (state_q)
        PLAY: begin
          if (handshake) begin
            if (reject) begin
              illegal_d = 1'b1;
            end else begin
              board_d = board_q | i_mask;
              moves_d = moves_q + 4'd1;
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (winner != 2'b00) begin
            result_d = winner;
            state_d  = OVER;
          end else if (moves_q == 4'd9) begin
            result_d = 2'b10;
            state_d  = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = PLAY;
          end
        end
        OVER:    state_d = OVER;
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= PLAY;
      board_q   <= 18'h0;
      turn_q    <= 1'b1;
      illegal_q <= 1'b0;
      result_q  <= 2'b00;
      moves_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      moves_q   <= moves_d;
    end
  end

  assign o_ready   = (state_q == PLAY);
  assign o_board   = board_q;
  assign o_turn    = turn_q;
  assign o_illegal = illegal_q;
  assign o_result  = result_q;
  assign o_moves   = moves_q;

endmodule

// File: tb/tb_board_state.sv
// Bench for board_state: game-level reference model feeds an expected queue of
// per-cycle output snapshots; a monitor pops and compares after each edge.
module tb_board_state;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_new_game, i_valid, i_bad_move, i_user;
  logic [17:0] i_mask;
  logic        o_ready, o_turn, o_illegal;
  logic [17:0] o_board;
  logic [1:0]  o_result;
  logic [3:0]  o_moves;

  board_state dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_new_game (i_new_game),
    .i_valid    (i_valid),
    .i_mask     (i_mask),
    .i_bad_move (i_bad_move),
    .i_user     (i_user),
    .o_ready    (o_ready),
    .o_board    (o_board),
    .o_turn     (o_turn),
    .o_illegal  (o_illegal),
    .o_result   (o_result),
    .o_moves    (o_moves)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [26:0] exp_q[$];
  localparam logic [26:0] RESET_SNAP = {1'b1, 18'h0, 1'b1, 1'b0, 2'b00, 4'd0};

  function automatic logic [26:0] dut_snap();
    return {o_ready, o_board, o_turn, o_illegal, o_result, o_moves};
  endfunction

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got rdy=%b brd=%h turn=%b ill=%b res=%b mv=%0d, expected rdy=%b brd=%h turn=%b ill=%b res=%b mv=%0d",
               name, $time, act[26], act[25:8], act[7], act[6], act[5:4], act[3:0],
               exp[26], exp[25:8], exp[7], exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  // ---------------- reference model (game level) ----------------
  localparam int LINES [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                                  '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
  int         m_cell [1:9];
  bit         m_turn;
  int         m_moves;
  logic [1:0] m_result;
  bit         m_illegal;
  int         m_phase;  // 0 waiting for a move, 1 evaluating, 2 game finished

  task automatic m_reset();
    for (int k = 1; k <= 9; k++) m_cell[k] = 0;
    m_turn = 1'b1; m_moves = 0; m_result = 2'b00; m_illegal = 1'b0; m_phase = 0;
  endtask

  function automatic logic [17:0] m_board();
    logic [17:0] b;
    b = 18'h0;
    for (int k = 1; k <= 9; k++) b = b | (18'(m_cell[k]) << (18 - 2 * k));
    return b;
  endfunction

  function automatic logic [26:0] m_snap();
    return {m_phase == 0, m_board(), m_turn, m_illegal, m_result, 4'(m_moves)};
  endfunction

  function automatic int mask_cell(input logic [17:0] mask, input int k);
    return int'((mask >> (18 - 2 * k)) & 18'h3);
  endfunction

  task automatic m_step(input bit ng, input bit v, input bit bad, input bit u,
                        input logic [17:0] mask);
    bit overlap;
    int win;
    m_illegal = 1'b0;
    if (ng) begin
      m_reset();
    end else if (m_phase == 0) begin
      if (v) begin
        overlap = 1'b0;
        for (int k = 1; k <= 9; k++)
          if (m_cell[k] != 0 && (mask_cell(mask, k) & 1) != 0) overlap = 1'b1;
        if (bad || mask == 18'h0 || u != m_turn || overlap) begin
          m_illegal = 1'b1;
        end else begin
          for (int k = 1; k <= 9; k++) m_cell[k] = m_cell[k] | mask_cell(mask, k);
          m_moves++;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      win = 0;
      for (int l = 0; l < 8; l++)
        if (win == 0 && m_cell[LINES[l][0]] != 0 &&
            m_cell[LINES[l][0]] == m_cell[LINES[l][1]] &&
            m_cell[LINES[l][1]] == m_cell[LINES[l][2]])
          win = m_cell[LINES[l][0]];
      if (win != 0) begin
        m_result = 2'(win); m_phase = 2;
      end else if (m_moves == 9) begin
        m_result = 2'b10; m_phase = 2;
      end else begin
        m_turn = !m_turn; m_phase = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit ng, input bit v, input bit bad, input bit u,
                       input logic [17:0] mask);
    @(negedge clk);
    i_new_game = ng; i_valid = v; i_bad_move = bad; i_user = u; i_mask = mask;
    m_step(ng, v, bad, u, mask);
    exp_q.push_back(m_snap());
  endtask

  function automatic logic [17:0] cmask(input int k, input bit u);
    logic [17:0] m;
    m = u ? 18'h3 : 18'h1;
    return m << (18 - 2 * k);
  endfunction

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 18'h0);
  endtask

  task automatic new_game();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 18'h0);
  endtask

  task automatic play(input int k, input bit u);
    drive(1'b0, 1'b1, 1'b0, u, cmask(k, u));
    if (m_phase == 1) idle();
  endtask

  // Asserts reset between edges while the queue is drained.
  task automatic async_reset(input string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check(name, dut_snap(), RESET_SNAP);
    m_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle", dut_snap(), exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ng, v, bad, u;
    logic [17:0] mask;
    int r;
    rst_n = 1'b0;
    i_new_game = 1'b0; i_valid = 1'b0; i_bad_move = 1'b0; i_user = 1'b0; i_mask = 18'h0;
    m_reset();
    #22;
    check("reset", dut_snap(), RESET_SNAP);
    #1;
    rst_n = 1'b1;

    // X takes the centre
    play(5, 1'b1); idle(); idle();
    // occupied cell
    new_game(); play(1, 1'b1); play(2, 1'b0); play(1, 1'b1); idle();
    // wrong side, then decoder-flagged bad key
    new_game(); drive(1'b0, 1'b1, 1'b0, 1'b0, 18'h10000); idle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 18'h0); idle();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 18'h0); idle();
    // X wins on the top row, further offers ignored
    new_game();
    play(1, 1'b1); play(4, 1'b0); play(2, 1'b1); play(5, 1'b0); play(3, 1'b1);
    play(6, 1'b0); drive(1'b0, 1'b1, 1'b0, 1'b1, cmask(7, 1'b1)); idle();
    // draw
    new_game();
    play(5, 1'b1); play(1, 1'b0); play(9, 1'b1); play(3, 1'b0); play(2, 1'b1);
    play(8, 1'b0); play(4, 1'b1); play(6, 1'b0); play(7, 1'b1); idle();
    new_game(); idle();
    // new game overrides a handshake in the same cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1, cmask(5, 1'b1)); idle();
    // new game during evaluation
    drive(1'b0, 1'b1, 1'b0, 1'b1, cmask(9, 1'b1)); new_game(); idle();
    // async reset mid-evaluation and mid-game-over
    drive(1'b0, 1'b1, 1'b0, 1'b1, cmask(5, 1'b1));
    async_reset("async_rst_check");
    play(1, 1'b1); play(4, 1'b0); play(2, 1'b1); play(5, 1'b0); play(3, 1'b1); idle();
    async_reset("async_rst_over");
    idle();

    // randomized play
    repeat (800) begin
      ng  = ($urandom_range(0, 59) == 0) || (m_phase == 2 && $urandom_range(0, 5) == 0);
      v   = ($urandom_range(0, 9) < 7);
      u   = ($urandom_range(0, 99) < 85) ? m_turn : !m_turn;
      bad = ($urandom_range(0, 24) == 0);
      r   = $urandom_range(0, 24);
      if (r == 0)      mask = 18'h0;
      else if (r == 1) mask = 18'($urandom);
      else             mask = cmask($urandom_range(1, 9), u);
      drive(ng, v, bad, u, mask);
    end
    idle(); idle();
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected snapshots never compared, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
